rx_decoder: RTL and testbench
=============================

RX_DECODER -- requirements
Module: rx_decoder

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 8, meaning clk cycles per USB bit.
REQ-002 The block SHALL have parameter SAMPLE_PT, default 3, meaning the bit-timer count at which the line is sampled (0..CLKS_PER_BIT-1).
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port dplus_in, input, 1, D+ line, already synchronized to clk.
REQ-006 The block SHALL have port dminus_in, input, 1, D- line, already synchronized to clk.
REQ-007 The block SHALL have port rcv_data, output, 8, last completed byte, LSB received first.
REQ-008 The block SHALL have port byte_valid, output, 1, one-cycle strobe when rcv_data is updated.
REQ-009 The block SHALL have port eop_det, output, 1, one-cycle strobe when a packet ends.
REQ-010 The block SHALL have port rx_err, output, 1, one-cycle strobe on any receive error.
REQ-011 The block SHALL have port receiving, output, 1, high from the sync start edge until return to IDLE.

Function
REQ-012 The state machine SHALL have states IDLE, SYNC, DATA and EOP.
REQ-013 In IDLE, the bit counter SHALL hold 0; a 1->0 transition on dplus_in SHALL move the machine to SYNC and start the counter.
REQ-014 The bit counter SHALL count 0..CLKS_PER_BIT-1 and wrap; any dplus_in transition outside IDLE SHALL reload it to 0 (resync).
REQ-015 A sample strobe SHALL occur when counter == SAMPLE_PT.
REQ-016 A sample with dplus_in=0 and dminus_in=0 SHALL be SE0; otherwise decoded bit = 1 if sampled dplus equals the previous sampled dplus, else 0 (NRZI). The previous-dplus register SHALL reset to 1.
REQ-017 The unstuffer SHALL count consecutive decoded 1s; the bit after six 1s SHALL be discarded if 0; if it is 1, rx_err SHALL pulse and the machine SHALL go to IDLE.
REQ-018 Unstuffed bits SHALL shift in MSB-first into an 8-bit register (shift right), giving LSB-first byte order.
REQ-019 In SYNC, after 8 unstuffed bits the register SHALL equal 8'h80 to go to DATA; otherwise rx_err SHALL pulse and the machine SHALL go to IDLE.
REQ-020 In DATA, every 8th unstuffed bit SHALL load rcv_data and pulse byte_valid one cycle after the completing sample.
REQ-021 An SE0 sample in DATA SHALL move the machine to EOP; an SE0 sample in SYNC SHALL pulse rx_err and move it to IDLE.
REQ-022 In EOP, a further SE0 sample SHALL keep the machine in EOP; a J sample (dplus=1, dminus=0) SHALL pulse eop_det and move it to IDLE; a K sample SHALL pulse rx_err and move it to IDLE.
REQ-023 If the partial bit count is non-zero at SE0 entry, rx_err SHALL pulse together with eop_det.
REQ-024 The outputs byte_valid, eop_det and rx_err SHALL be registered and SHALL never be high for more than one consecutive cycle each.
REQ-025 The byte, bit and ones counters SHALL clear on every entry to IDLE.

Reset
REQ-026 On n_rst low, the block SHALL set state=IDLE, counters=0, previous-dplus=1, rcv_data=8'h00, and all strobes and receiving low, regardless of activity.
REQ-027 Reset release mid-packet SHALL resume in IDLE, waiting for the next 1->0 edge.

Structure
REQ-028 The state enum, the SYNC_BYTE constant 8'h80 and the stuff limit 6 SHALL reside in shared package usb_rx_pkg.
REQ-029 The bit counter and resync logic SHALL form sub-module rx_bit_timer, which outputs the sample strobe.

Verification
REQ-030 Sync KJKJKJKK, then byte 8'hA5 (NRZI), then SE0,SE0,J -> byte_valid with rcv_data=8'hA5, then eop_det; rx_err stays 0.
REQ-031 Byte 8'hFF with a stuffed 0 after six 1s -> rcv_data=8'hFF, the stuffed bit is dropped, and rx_err stays 0.
REQ-032 Seven consecutive decoded 1s -> rx_err pulses, receiving falls, and there is no byte_valid.
REQ-033 Sync byte decoding to 8'h81 -> rx_err and return to IDLE.
REQ-034 SE0 after 3 data bits -> eop_det and rx_err in the same cycle.
REQ-035 An edge jittered +/-2 clk mid-packet -> decoding is correct via resync; n_rst asserted mid-byte -> all outputs are 0 next cycle.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_EOP  = 2'd3
  } rx_state_e;

  // Sync pattern KJKJKJKK decodes to 0000_0001 in arrival order, i.e. 8'h80 LSB-first.
  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  // Consecutive 1s after which the transmitter inserts a 0.
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: free-runs while a packet is active, realigns on every
// D+ transition and strobes once per bit at the configured sample point.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic dplus_in,
  input  logic run,
  output logic fall_edge,
  output logic sample
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SPT  = CW'(SAMPLE_PT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          line_q, line_d;
  logic          edge_any;

  assign edge_any  = dplus_in ^ line_q;
  assign fall_edge = line_q & ~dplus_in;
  assign sample    = run & (cnt_q == SPT);

  // Counter holds at zero while idle, reloads on any line edge, else wraps.
  always_comb begin
    line_d = dplus_in;
    cnt_d  = cnt_q;
    if (!run || edge_any) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Timer and previous-line registers; line idles at J so it resets high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      line_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/rx_decoder.sv
// USB receive decoder: NRZI decode, bit unstuffing, sync check, byte
// assembly and end-of-packet detection.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | line idle, waiting for a 1->0 edge on D+
//   SYNC    | collecting the first 8 unstuffed bits, must equal SYNC_BYTE
//   DATA    | assembling bytes; SE0 sample ends the packet
//   EOP     | SE0 seen; J completes the packet, K is an error
module rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dplus_in,
  input  logic       dminus_in,
  output logic [7:0] rcv_data,
  output logic       byte_valid,
  output logic       eop_det,
  output logic       rx_err,
  output logic       receiving
);

  rx_state_e  state_q, state_d;
  logic       prev_dp_q, prev_dp_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] ones_q, ones_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rcv_data_q, rcv_data_d;
  logic       partial_q, partial_d;
  logic       byte_valid_q, byte_valid_d;
  logic       eop_det_q, eop_det_d;
  logic       rx_err_q, rx_err_d;

  logic       fall_edge, sample, go_idle;
  logic       se0, line_j, nrzi_bit;
  logic [7:0] shift_next;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_PT   (SAMPLE_PT)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .dplus_in (dplus_in),
    .run      (state_q != ST_IDLE),
    .fall_edge(fall_edge),
    .sample   (sample)
  );

  assign se0        = ~dplus_in & ~dminus_in;
  assign line_j     = dplus_in & ~dminus_in;
  assign nrzi_bit   = (dplus_in == prev_dp_q);
  assign shift_next = {nrzi_bit, shift_q[7:1]};

  // Next-state, unstuffing and byte assembly, all qualified by the sample strobe.
  always_comb begin
    state_d      = state_q;
    prev_dp_d    = prev_dp_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    shift_d      = shift_q;
    rcv_data_d   = rcv_data_q;
    partial_d    = partial_q;
    byte_valid_d = 1'b0;
    eop_det_d    = 1'b0;
    rx_err_d     = 1'b0;
    go_idle      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        prev_dp_d = 1'b1;
        if (fall_edge) state_d = ST_SYNC;
      end

      ST_SYNC, ST_DATA: begin
        if (sample) begin
          if (se0) begin
            if (state_q == ST_SYNC) begin
              rx_err_d = 1'b1;
              go_idle  = 1'b1;
            end else begin
              state_d   = ST_EOP;
              partial_d = (bit_cnt_q != 3'd0);
            end
          end else begin
            prev_dp_d = dplus_in;
            if (ones_q == STUFF_LIMIT) begin
              // A 0 here is the stuffed bit and is dropped; a 1 is a stuffing violation.
              ones_d = 3'd0;
              if (nrzi_bit) begin
                rx_err_d = 1'b1;
                go_idle  = 1'b1;
              end
            end else begin
              ones_d    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
              shift_d   = shift_next;
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == ST_SYNC) begin
                  if (shift_next == SYNC_BYTE) begin
                    state_d = ST_DATA;
                  end else begin
                    rx_err_d = 1'b1;
                    go_idle  = 1'b1;
                  end
                end else begin
                  rcv_data_d   = shift_next;
                  byte_valid_d = 1'b1;
                end
              end
            end
          end
        end
      end

      ST_EOP: begin
        if (sample && !se0) begin
          if (line_j) begin
            eop_det_d = 1'b1;
            rx_err_d  = partial_q;
          end else begin
            rx_err_d = 1'b1;
          end
          go_idle = 1'b1;
        end
      end

      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      ones_d    = 3'd0;
      shift_d   = 8'h00;
      partial_d = 1'b0;
      prev_dp_d = 1'b1;
    end
  end

  // State, datapath and registered strobes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      prev_dp_q    <= 1'b1;
      bit_cnt_q    <= 3'd0;
      ones_q       <= 3'd0;
      shift_q      <= 8'h00;
      rcv_data_q   <= 8'h00;
      partial_q    <= 1'b0;
      byte_valid_q <= 1'b0;
      eop_det_q    <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_dp_q    <= prev_dp_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      shift_q      <= shift_d;
      rcv_data_q   <= rcv_data_d;
      partial_q    <= partial_d;
      byte_valid_q <= byte_valid_d;
      eop_det_q    <= eop_det_d;
      rx_err_q     <= rx_err_d;
    end
  end

  assign rcv_data   = rcv_data_q;
  assign byte_valid = byte_valid_q;
  assign eop_det    = eop_det_q;
  assign rx_err     = rx_err_q;
  assign receiving  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_decoder.sv
// Randomized bench for rx_decoder: packets are built as logical bytes,
// bit-stuffed and NRZI-encoded into line symbols, then driven with optional
// edge jitter. Expected events go into a queue; a monitor pops on each strobe.
module tb_rx_decoder;

  localparam int CPB = 8;
  localparam int S_J = 0, S_K = 1, S_SE0 = 2;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       dplus_in = 1'b1;
  logic       dminus_in = 1'b0;
  logic [7:0] rcv_data;
  logic       byte_valid, eop_det, rx_err, receiving;

  rx_decoder #(.CLKS_PER_BIT(CPB), .SAMPLE_PT(3)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .dplus_in  (dplus_in),
    .dminus_in (dminus_in),
    .rcv_data  (rcv_data),
    .byte_valid(byte_valid),
    .eop_det   (eop_det),
    .rx_err    (rx_err),
    .receiving (receiving)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [10:0] exp_q[$];
  logic        bit_q[$];
  int          sym_q[$];
  int          dur_q[$];
  int          enc_level;
  int          enc_ones;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic logic [10:0] ev_byte(input logic [7:0] b);
    return {3'b100, b};
  endfunction
  function automatic logic [10:0] ev_eop(input logic with_err);
    return {2'b01, with_err, 8'h00};
  endfunction
  function automatic logic [10:0] ev_err();
    return {3'b001, 8'h00};
  endfunction

  function automatic void put_sym(input int s, input int d);
    sym_q.push_back(s);
    dur_q.push_back(d);
  endfunction

  function automatic void put_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) bit_q.push_back(v[i]);
  endfunction

  // NRZI: 0 toggles the line, 1 holds it; optionally insert a 0 after six 1s.
  function automatic void encode(input bit stuff);
    foreach (bit_q[i]) begin
      if (!bit_q[i]) enc_level = 1 - enc_level;
      put_sym(enc_level ? S_J : S_K, CPB);
      enc_ones = bit_q[i] ? enc_ones + 1 : 0;
      if (stuff && enc_ones == 6) begin
        enc_level = 1 - enc_level;
        put_sym(enc_level ? S_J : S_K, CPB);
        enc_ones = 0;
      end
    end
    bit_q.delete();
  endfunction

  function automatic void start_pkt();
    for (int i = 0; i < 3; i++) put_sym(S_J, CPB);
    enc_level = 1;
    enc_ones  = 0;
  endfunction

  function automatic void end_eop();
    put_sym(S_SE0, CPB);
    put_sym(S_SE0, CPB);
    put_sym(S_J, CPB);
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) put_sym(S_J, CPB);
  endfunction

  // Shift every fourth in-packet symbol boundary by -2..+2 clocks.
  function automatic void jitter();
    for (int i = 6; i < sym_q.size() - 4; i += 4) begin
      int d;
      d = int'($urandom_range(4)) - 2;
      dur_q[i-1] += d;
      dur_q[i]   -= d;
    end
  endfunction

  function automatic bit has_six_ones(input logic [7:0] v);
    int run;
    run = 0;
    for (int i = 0; i < 8; i++) begin
      run = v[i] ? run + 1 : 0;
      if (run >= 6) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Entered and left at posedge+1.
  task automatic drive_syms();
    for (int i = 0; i < sym_q.size(); i++) begin
      dplus_in  = (sym_q[i] == S_J);
      dminus_in = (sym_q[i] == S_K);
      repeat (dur_q[i]) @(posedge clk);
      #1;
    end
    sym_q.delete();
    dur_q.delete();
  endtask

  // Monitor: pop and compare on every strobe, and flag back-to-back strobes.
  logic [10:0] obs, want_ev;
  logic        bv_d1 = 1'b0, eop_d1 = 1'b0, err_d1 = 1'b0;
  always @(negedge clk) begin
    if (n_rst) begin
      if (byte_valid || eop_det || rx_err) begin
        obs = {byte_valid, eop_det, rx_err, byte_valid ? rcv_data : 8'h00};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event got=%h want=none t=%0t", obs, $time);
        end else begin
          want_ev = exp_q.pop_front();
          check("event", obs, want_ev);
        end
      end
      if (bv_d1)  check("byte_valid_one_cycle", byte_valid, 1'b0);
      if (eop_d1) check("eop_det_one_cycle", eop_det, 1'b0);
      if (err_d1) check("rx_err_one_cycle", rx_err, 1'b0);
    end
    bv_d1  = byte_valid;
    eop_d1 = eop_det;
    err_d1 = rx_err;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         nb, nbits;
    bit         part;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {rcv_data, byte_valid, eop_det, rx_err, receiving}, 12'h000);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Sync then 8'hA5, SE0 SE0 J
    start_pkt(); put_bits(8'h80, 8); put_bits(8'hA5, 8); encode(1'b1); end_eop(); idle(3);
    exp_q.push_back(ev_byte(8'hA5));
    exp_q.push_back(ev_eop(1'b0));
    drive_syms();
    check("receiving_after_a5", receiving, 1'b0);

    // 8'hFF needs a stuffed 0 after the fifth data bit
    start_pkt(); put_bits(8'h80, 8); put_bits(8'hFF, 8); encode(1'b1); end_eop(); idle(3);
    exp_q.push_back(ev_byte(8'hFF));
    exp_q.push_back(ev_eop(1'b0));
    drive_syms();

    // Seven consecutive 1s (sync's trailing 1 plus six data 1s) without stuffing
    start_pkt(); put_bits(8'h80, 8); encode(1'b1); put_bits(8'h7F, 7); encode(1'b0); idle(3);
    exp_q.push_back(ev_err());
    drive_syms();
    check("receiving_after_stuff_err", receiving, 1'b0);

    // Sync decoding to 8'h81: a short K glitch starts the receiver, first bit reads as 1
    start_pkt(); put_sym(S_K, 2); put_bits(8'h81, 8); encode(1'b1); idle(3);
    exp_q.push_back(ev_err());
    drive_syms();
    check("receiving_after_sync81", receiving, 1'b0);

    // SE0 after 3 data bits
    start_pkt(); put_bits(8'h80, 8); put_bits(8'h05, 3); encode(1'b1); end_eop(); idle(3);
    exp_q.push_back(ev_eop(1'b1));
    drive_syms();

    // SE0 during sync
    start_pkt(); put_bits(8'h80, 4); encode(1'b1); end_eop(); idle(3);
    exp_q.push_back(ev_err());
    drive_syms();

    // K after SE0 in EOP
    start_pkt(); put_bits(8'h80, 8); put_bits(8'h3C, 8); encode(1'b1);
    put_sym(S_SE0, CPB); put_sym(S_SE0, CPB); put_sym(S_K, CPB); idle(3);
    exp_q.push_back(ev_byte(8'h3C));
    exp_q.push_back(ev_err());
    drive_syms();

    // Random bad sync bytes (first bit is always 0 after the start edge)
    for (int p = 0; p < 6; p++) begin
      b = 8'($urandom) & 8'hFE;
      while (b == 8'h80 || has_six_ones(b)) b = 8'($urandom) & 8'hFE;
      start_pkt(); put_bits(b, 8); encode(1'b1); idle(3);
      exp_q.push_back(ev_err());
      drive_syms();
    end

    // Random packets, some ending mid-byte, some with jittered edges
    for (int p = 0; p < 24; p++) begin
      nb   = int'($urandom_range(4, 1));
      part = ($urandom_range(3) == 0);
      start_pkt(); put_bits(8'h80, 8);
      for (int k = 0; k < nb; k++) begin
        b = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
        put_bits(b, 8);
        exp_q.push_back(ev_byte(b));
      end
      if (part) begin
        nbits = int'($urandom_range(7, 1));
        put_bits(8'($urandom), nbits);
      end
      exp_q.push_back(ev_eop(part));
      encode(1'b1); end_eop(); idle(3);
      if ($urandom_range(1) == 1) jitter();
      drive_syms();
      check("receiving_after_rand_pkt", receiving, 1'b0);
    end

    // Reset mid-byte, then a clean packet
    start_pkt(); put_bits(8'h80, 8); put_bits(8'h3C, 4); encode(1'b1);
    drive_syms();
    check("receiving_mid_packet", receiving, 1'b1);
    n_rst = 1'b0;
    @(negedge clk);
    check("reset_mid_byte_outputs", {rcv_data, byte_valid, eop_det, rx_err, receiving}, 12'h000);
    dplus_in  = 1'b1;
    dminus_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("receiving_after_reset", receiving, 1'b0);
    @(posedge clk);
    #1;
    start_pkt(); put_bits(8'h80, 8); put_bits(8'h5A, 8); encode(1'b1); end_eop(); idle(3);
    exp_q.push_back(ev_byte(8'h5A));
    exp_q.push_back(ev_eop(1'b0));
    drive_syms();

    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(posedge clk);
    check("leftover_expected_events", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
